// File: rtl/ff_act_pingpong_buffer.sv
// Double-buffered activation/adot row store between FF_processor_set and the next junction's reader.
// One bank fills row by row while the other drains; in_ready stalls the producer once both banks are full.
module ff_act_pingpong_buffer #(
  parameter  int width = 12,
  parameter  int z     = 512,
  parameter  int fi    = 32,
  parameter  int p     = 64,
  localparam int N     = z / fi,
  localparam int cpc   = p / N,
  localparam int aw    = (cpc > 1) ? $clog2(cpc) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0][width-1:0]   act_in,
  input  logic [N-1:0][width-1:0]   adot_in,
  output logic                      rd_avail,
  input  logic                      rd_en,
  input  logic [aw-1:0]             rd_row,
  input  logic                      rd_release,
  output logic                      rd_valid,
  output logic [N-1:0][width-1:0]   act_rd,
  output logic [N-1:0][width-1:0]   adot_rd,
  output logic                      bank_wr,
  output logic                      bank_rd
);

  typedef logic [N-1:0][width-1:0] row_t;

  localparam logic [aw-1:0] last_row = aw'(cpc - 1);
  localparam logic [aw:0]   row_lim  = (aw + 1)'(cpc);

  row_t act_mem_r  [2][cpc];
  row_t adot_mem_r [2][cpc];

  logic          wb_r;
  logic          rb_r;
  logic [aw-1:0] wr_row_r;
  logic [1:0]    full_cnt_r;
  logic          rd_valid_r;
  row_t          act_rd_r;
  row_t          adot_rd_r;

  logic          wr_ok_s;
  logic          fill_done_s;
  logic          rel_ok_s;
  logic          rd_ok_s;
  logic [1:0]    full_cnt_nxt_s;

  assign in_ready = (full_cnt_r != 2'd2);
  assign rd_avail = (full_cnt_r != 2'd0);
  assign bank_wr  = wb_r;
  assign bank_rd  = rb_r;
  assign rd_valid = rd_valid_r;
  assign act_rd   = act_rd_r;
  assign adot_rd  = adot_rd_r;

  // Handshake qualification and filled-bank count; a fill and a release together cancel out.
  always_comb begin
    wr_ok_s        = in_valid && in_ready;
    fill_done_s    = wr_ok_s && (wr_row_r == last_row);
    rel_ok_s       = rd_release && rd_avail;
    rd_ok_s        = rd_en && rd_avail && ({1'b0, rd_row} < row_lim);
    full_cnt_nxt_s = full_cnt_r;
    if (fill_done_s && !rel_ok_s) begin
      full_cnt_nxt_s = full_cnt_r + 2'd1;
    end else if (rel_ok_s && !fill_done_s) begin
      full_cnt_nxt_s = full_cnt_r - 2'd1;
    end else begin
      full_cnt_nxt_s = full_cnt_r;
    end
  end

  // Bank pointers, fill row, and the registered read port; read data holds when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_r       <= 1'b0;
      rb_r       <= 1'b0;
      wr_row_r   <= '0;
      full_cnt_r <= 2'd0;
      rd_valid_r <= 1'b0;
      act_rd_r   <= '0;
      adot_rd_r  <= '0;
    end else begin
      full_cnt_r <= full_cnt_nxt_s;
      if (wr_ok_s) begin
        if (fill_done_s) begin
          wr_row_r <= '0;
          wb_r     <= ~wb_r;
        end else begin
          wr_row_r <= wr_row_r + aw'(1);
        end
      end
      if (rel_ok_s) begin
        rb_r <= ~rb_r;
      end
      rd_valid_r <= rd_ok_s;
      if (rd_ok_s) begin
        act_rd_r  <= act_mem_r[rb_r][rd_row];
        adot_rd_r <= adot_mem_r[rb_r][rd_row];
      end
    end
  end

  // Row storage is deliberately left unreset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      act_mem_r[wb_r][wr_row_r]  <= act_in;
      adot_mem_r[wb_r][wr_row_r] <= adot_in;
    end
  end

endmodule

// File: tb/tb_ff_act_pingpong_buffer.sv
// Self-checking bench: fixed vector table, hand sequences for reset/sign corners, and a random run
// compared against a queue-of-filled-banks reference model.
module tb_ff_act_pingpong_buffer;

  localparam int W   = 12;
  localparam int NN  = 16;
  localparam int CPC = 4;
  localparam int AW  = 2;
  localparam int RW  = NN * W;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid, in_ready, rd_avail, rd_en, rd_release, rd_valid, bank_wr, bank_rd;
  logic [NN-1:0][W-1:0] act_in, adot_in, act_rd, adot_rd;
  logic [AW-1:0]        rd_row;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ff_act_pingpong_buffer #(.width(W), .z(512), .fi(32), .p(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .act_in(act_in), .adot_in(adot_in), .rd_avail(rd_avail), .rd_en(rd_en),
    .rd_row(rd_row), .rd_release(rd_release), .rd_valid(rd_valid),
    .act_rd(act_rd), .adot_rd(adot_rd), .bank_wr(bank_wr), .bank_rd(bank_rd)
  );

  // Reference model: completed banks queue up in fill order; the reader owns the oldest one.
  logic [RW-1:0] m_act  [2][CPC];
  logic [RW-1:0] m_adot [2][CPC];
  int            m_q[$];
  int            m_wb;
  int            m_fill;
  logic          m_rv;
  logic [RW-1:0] m_act_rd, m_adot_rd;

  function automatic int m_rb();
    return (m_q.size() > 0) ? m_q[0] : m_wb;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_wb      = 0;
    m_fill    = 0;
    m_rv      = 1'b0;
    m_act_rd  = '0;
    m_adot_rd = '0;
  endfunction

  function automatic void model_step();
    bit avail = (m_q.size() > 0);
    bit rdy   = (m_q.size() < 2);
    int rb    = m_rb();
    if (rd_en && avail && int'(rd_row) < CPC) begin
      m_rv      = 1'b1;
      m_act_rd  = m_act[rb][rd_row];
      m_adot_rd = m_adot[rb][rd_row];
    end else begin
      m_rv = 1'b0;
    end
    if (rd_release && avail) void'(m_q.pop_front());
    if (in_valid && rdy) begin
      m_act[m_wb][m_fill]  = act_in;
      m_adot[m_wb][m_fill] = adot_in;
      m_fill++;
      if (m_fill == CPC) begin
        m_fill = 0;
        m_q.push_back(m_wb);
        m_wb = 1 - m_wb;
      end
    end
  endfunction

  function automatic void chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endfunction

  function automatic logic [RW-1:0] mk(input logic [11:0] base);
    logic [NN-1:0][W-1:0] r;
    for (int k = 0; k < NN; k++) r[k] = base + 12'(k);
    return r;
  endfunction

  function automatic logic [RW-1:0] rnd_row();
    logic [RW-1:0] r;
    for (int k = 0; k < NN; k++) r[k*W +: W] = W'($urandom);
    return r;
  endfunction

  // One clock: drive inputs, advance the model, then compare every output after the edge.
  task automatic cycle(input logic iv, input logic [RW-1:0] a, input logic [RW-1:0] d,
                       input logic re, input logic [AW-1:0] row, input logic rel);
    in_valid = iv; act_in = a; adot_in = d; rd_en = re; rd_row = row; rd_release = rel;
    model_step();
    @(posedge clk);
    #1;
    chk("rd_valid", RW'(rd_valid), RW'(m_rv));
    chk("act_rd",   act_rd,  m_act_rd);
    chk("adot_rd",  adot_rd, m_adot_rd);
    chk("in_ready", RW'(in_ready), RW'(m_q.size() < 2));
    chk("rd_avail", RW'(rd_avail), RW'(m_q.size() > 0));
    chk("bank_wr",  RW'(bank_wr),  RW'(m_wb));
    chk("bank_rd",  RW'(bank_rd),  RW'(m_rb()));
  endtask

  typedef struct {
    bit iv; bit [11:0] wbase; bit re; bit [1:0] row; bit rel;
    bit rdy; bit av; bit rv; bit bw; bit br; bit ck; bit [11:0] ebase;
  } vec_t;

  function automatic vec_t v(bit iv, bit [11:0] wbase, bit re, bit [1:0] row, bit rel,
                             bit rdy, bit av, bit rv, bit bw, bit br, bit ck, bit [11:0] ebase);
    vec_t t;
    t.iv = iv; t.wbase = wbase; t.re = re; t.row = row; t.rel = rel;
    t.rdy = rdy; t.av = av; t.rv = rv; t.bw = bw; t.br = br; t.ck = ck; t.ebase = ebase;
    return t;
  endfunction

  vec_t          tv[28];
  logic [RW-1:0] neg_a, neg_d;

  initial begin
    //            iv    wbase    re    row   rel    rdy   av    rv    bw    br    ck    ebase
    tv[0]  = v(1'b1, 12'h000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    tv[1]  = v(1'b1, 12'h010, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    tv[2]  = v(1'b1, 12'h020, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    tv[3]  = v(1'b1, 12'h030, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    tv[4]  = v(1'b0, 12'h000, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000);
    tv[5]  = v(1'b0, 12'h000, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h010);
    tv[6]  = v(1'b0, 12'h000, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h020);
    tv[7]  = v(1'b0, 12'h000, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h030);
    tv[8]  = v(1'b1, 12'h100, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h030);
    tv[9]  = v(1'b1, 12'h110, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h030);
    tv[10] = v(1'b1, 12'h120, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h030);
    tv[11] = v(1'b1, 12'h130, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h030);
    tv[12] = v(1'b1, 12'h200, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h030);
    tv[13] = v(1'b1, 12'h200, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h030);
    tv[14] = v(1'b1, 12'h200, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h100);
    tv[15] = v(1'b1, 12'h210, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h130);
    tv[16] = v(1'b1, 12'h220, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h130);
    tv[17] = v(1'b1, 12'h230, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h120);
    tv[18] = v(1'b0, 12'h000, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h200);
    tv[19] = v(1'b0, 12'h000, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h230);
    tv[20] = v(1'b0, 12'h000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h230);
    tv[21] = v(1'b0, 12'h000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h230);
    tv[22] = v(1'b1, 12'h300, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h230);
    tv[23] = v(1'b1, 12'h310, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h230);
    tv[24] = v(1'b1, 12'h320, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h230);
    tv[25] = v(1'b1, 12'h330, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h230);
    tv[26] = v(1'b0, 12'h000, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h310);
    tv[27] = v(1'b0, 12'h000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h310);

    rst_n = 1'b0; in_valid = 1'b0; act_in = '0; adot_in = '0;
    rd_en = 1'b0; rd_row = '0; rd_release = 1'b0;
    model_reset();
    #12;
    chk("reset in_ready", RW'(in_ready), RW'(1'b1));
    chk("reset rd_avail", RW'(rd_avail), RW'(1'b0));
    chk("reset rd_valid", RW'(rd_valid), RW'(1'b0));
    chk("reset act_rd",   act_rd, '0);
    chk("reset bank_wr",  RW'(bank_wr), RW'(1'b0));
    chk("reset bank_rd",  RW'(bank_rd), RW'(1'b0));
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill/read, both-full stall, release-with-fill collision, reads while empty.
    for (int i = 0; i < 28; i++) begin
      cycle(tv[i].iv, mk(tv[i].wbase), ~mk(tv[i].wbase), tv[i].re, tv[i].row, tv[i].rel);
      chk($sformatf("vec%0d in_ready", i), RW'(in_ready), RW'(tv[i].rdy));
      chk($sformatf("vec%0d rd_avail", i), RW'(rd_avail), RW'(tv[i].av));
      chk($sformatf("vec%0d rd_valid", i), RW'(rd_valid), RW'(tv[i].rv));
      chk($sformatf("vec%0d bank_wr", i),  RW'(bank_wr),  RW'(tv[i].bw));
      chk($sformatf("vec%0d bank_rd", i),  RW'(bank_rd),  RW'(tv[i].br));
      if (tv[i].ck) begin
        chk($sformatf("vec%0d act_rd", i),  act_rd,  mk(tv[i].ebase));
        chk($sformatf("vec%0d adot_rd", i), adot_rd, ~mk(tv[i].ebase));
      end
    end

    // Asynchronous reset in the middle of a fill while a read is in flight.
    for (int r = 0; r < CPC; r++) cycle(1'b1, rnd_row(), rnd_row(), 1'b0, 2'd0, 1'b0);
    for (int r = 0; r < 2; r++)   cycle(1'b1, rnd_row(), rnd_row(), 1'b1, 2'(r), 1'b0);
    chk("pre-reset rd_valid", RW'(rd_valid), RW'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("async in_ready", RW'(in_ready), RW'(1'b1));
    chk("async rd_avail", RW'(rd_avail), RW'(1'b0));
    chk("async rd_valid", RW'(rd_valid), RW'(1'b0));
    chk("async act_rd",   act_rd, '0);
    chk("async bank_wr",  RW'(bank_wr), RW'(1'b0));
    model_reset();
    in_valid = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int r = 0; r < CPC; r++) cycle(1'b1, rnd_row(), rnd_row(), 1'b0, 2'd0, 1'b0);
    for (int r = 0; r < CPC; r++) cycle(1'b0, '0, '0, 1'b1, 2'(r), 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 2'd0, 1'b1);

    // Sign-bit and all-ones patterns survive the round trip unchanged.
    neg_a = {NN{12'h800}};
    neg_d = {NN{12'hFFF}};
    for (int r = 0; r < CPC; r++) cycle(1'b1, neg_a, neg_d, 1'b0, 2'd0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 2'd3, 1'b0);
    chk("neg act_rd",  act_rd,  neg_a);
    chk("neg adot_rd", adot_rd, neg_d);
    cycle(1'b0, '0, '0, 1'b0, 2'd0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 3) != 0, rnd_row(), rnd_row(), $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), $urandom_range(0, 6) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
